h14tx_timings_generator: RTL and testbench

Runtime-configurable video timing generator for the HDMI 1.4 TX path: raster cursor plus registered DE/HSYNC/VSYNC and frame/line markers. Powers up in 1280x720p60 timing. Accepts a new timing set through a valid/ready port and switches only at a frame boundary, so downstream encoders never see a torn frame. Sits between the pixel-clock domain reset logic and the TMDS channel encoders / pattern sources.

---
 rtl/h14tx_timings_generator.sv | 206 ++++++++++++++++++++
 tb/tb_h14tx_timings_generator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/h14tx_timings_generator.sv
// Runtime-configurable raster timing generator: x/y cursor with registered DE, syncs and markers.
// New timing sets are shadowed and swapped in only on a frame wrap.
module h14tx_timings_generator #(
    parameter int BitWidth   = 12,
    parameter int BitHeight  = 11,
    parameter int HActive    = 1280,
    parameter int HSyncStart = 1390,
    parameter int HSyncEnd   = 1430,
    parameter int HTotal     = 1650,
    parameter int VActive    = 720,
    parameter int VSyncStart = 725,
    parameter int VSyncEnd   = 730,
    parameter int VTotal     = 750,
    parameter bit HSyncPol   = 1'b1,
    parameter bit VSyncPol   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [BitWidth-1:0]  cfg_h_active,
    input  logic [BitWidth-1:0]  cfg_h_sync_start,
    input  logic [BitWidth-1:0]  cfg_h_sync_end,
    input  logic [BitWidth-1:0]  cfg_h_total,
    input  logic [BitHeight-1:0] cfg_v_active,
    input  logic [BitHeight-1:0] cfg_v_sync_start,
    input  logic [BitHeight-1:0] cfg_v_sync_end,
    input  logic [BitHeight-1:0] cfg_v_total,
    input  logic                 cfg_hsync_pol,
    input  logic                 cfg_vsync_pol,
    output logic                 cfg_applied,
    output logic                 cfg_error,
    output logic [BitWidth-1:0]  x,
    output logic [BitHeight-1:0] y,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 line_start,
    output logic                 frame_start
);

    typedef enum logic {ST_IDLE, ST_PENDING} cfg_state_e;

    typedef struct packed {
        logic [BitWidth-1:0]  h_active;
        logic [BitWidth-1:0]  h_sync_start;
        logic [BitWidth-1:0]  h_sync_end;
        logic [BitWidth-1:0]  h_total;
        logic [BitHeight-1:0] v_active;
        logic [BitHeight-1:0] v_sync_start;
        logic [BitHeight-1:0] v_sync_end;
        logic [BitHeight-1:0] v_total;
        logic                 hsync_pol;
        logic                 vsync_pol;
    } timing_t;

    localparam timing_t RESET_TIMING = '{
        h_active:     BitWidth'(HActive),
        h_sync_start: BitWidth'(HSyncStart),
        h_sync_end:   BitWidth'(HSyncEnd),
        h_total:      BitWidth'(HTotal),
        v_active:     BitHeight'(VActive),
        v_sync_start: BitHeight'(VSyncStart),
        v_sync_end:   BitHeight'(VSyncEnd),
        v_total:      BitHeight'(VTotal),
        hsync_pol:    HSyncPol,
        vsync_pol:    VSyncPol
    };

    // Strobe values at cursor (0,0) under the reset timing.
    localparam logic RST_DE    = (HActive > 0) && (VActive > 0);
    localparam logic RST_HSYNC = ((HSyncStart == 0) && (HSyncEnd > 0)) ~^ HSyncPol;
    localparam logic RST_VSYNC = ((VSyncStart == 0) && (VSyncEnd > 0)) ~^ VSyncPol;

    cfg_state_e           state_q, state_d;
    timing_t              active_q, active_d;
    timing_t              shadow_q, shadow_d;
    timing_t              cfg_in;
    logic [BitWidth-1:0]  x_q, x_d;
    logic [BitHeight-1:0] y_q, y_d;
    logic                 de_q, de_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 cfg_applied_q, cfg_applied_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 cfg_ok;
    logic                 line_end;
    logic                 frame_end;

    always_comb begin
        cfg_in = '{
            h_active:     cfg_h_active,
            h_sync_start: cfg_h_sync_start,
            h_sync_end:   cfg_h_sync_end,
            h_total:      cfg_h_total,
            v_active:     cfg_v_active,
            v_sync_start: cfg_v_sync_start,
            v_sync_end:   cfg_v_sync_end,
            v_total:      cfg_v_total,
            hsync_pol:    cfg_hsync_pol,
            vsync_pol:    cfg_vsync_pol
        };
        cfg_ok = (cfg_in.h_active != '0)
              && (cfg_in.h_active <= cfg_in.h_sync_start)
              && (cfg_in.h_sync_start < cfg_in.h_sync_end)
              && (cfg_in.h_sync_end <= cfg_in.h_total)
              && (cfg_in.h_total >= BitWidth'(2))
              && (cfg_in.v_active != '0)
              && (cfg_in.v_active <= cfg_in.v_sync_start)
              && (cfg_in.v_sync_start < cfg_in.v_sync_end)
              && (cfg_in.v_sync_end <= cfg_in.v_total)
              && (cfg_in.v_total != '0);

        line_end  = (x_q == active_q.h_total - BitWidth'(1));
        frame_end = line_end && (y_q == active_q.v_total - BitHeight'(1));

        state_d       = state_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        x_d           = x_q;
        y_d           = y_q;
        cfg_applied_d = 1'b0;
        cfg_error_d   = 1'b0;

        if (en) begin
            if (line_end) begin
                x_d = '0;
                y_d = frame_end ? '0 : y_q + BitHeight'(1);
            end else begin
                x_d = x_q + BitWidth'(1);
            end
            if (frame_end && (state_q == ST_PENDING)) begin
                active_d      = shadow_q;
                state_d       = ST_IDLE;
                cfg_applied_d = 1'b1;
            end
        end

        // Offers are judged against the pre-edge state, so an acceptance on a
        // wrap cycle leaves that wrap on the old timing.
        if ((state_q == ST_IDLE) && cfg_valid) begin
            if (cfg_ok) begin
                shadow_d = cfg_in;
                state_d  = ST_PENDING;
            end else begin
                cfg_error_d = 1'b1;
            end
        end

        // Strobes decode the next cursor so they line up with x/y exactly.
        de_d          = (x_d < active_d.h_active) && (y_d < active_d.v_active);
        hsync_d       = ((x_d >= active_d.h_sync_start) && (x_d < active_d.h_sync_end)) ~^ active_d.hsync_pol;
        vsync_d       = ((y_d >= active_d.v_sync_start) && (y_d < active_d.v_sync_end)) ~^ active_d.vsync_pol;
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);
        cfg_ready_d   = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            active_q      <= RESET_TIMING;
            shadow_q      <= RESET_TIMING;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= RST_DE;
            hsync_q       <= RST_HSYNC;
            vsync_q       <= RST_VSYNC;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            cfg_ready_q   <= 1'b1;
            cfg_applied_q <= 1'b0;
            cfg_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_applied_q <= cfg_applied_d;
            cfg_error_q   <= cfg_error_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_applied = cfg_applied_q;
    assign cfg_error   = cfg_error_q;
    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_h14tx_timings_generator.sv
// Bench for h14tx_timings_generator: the model tracks the enabled-cycle index within a frame
// and derives x/y by division, with config acceptance and frame-boundary apply.
module tb_h14tx_timings_generator;

    typedef struct {
        int ha, hss, hse, ht;
        int va, vss, vse, vt;
        bit hp, vp;
    } cfg_t;

    // Reduced reset raster so several whole frames fit in the run.
    localparam cfg_t DEF = '{ha: 20, hss: 24, hse: 27, ht: 30,
                             va: 10, vss: 12, vse: 14, vt: 16, hp: 1'b1, vp: 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, cfg_applied, cfg_error;
    logic [11:0] x;
    logic [10:0] y;
    logic        de, hsync, vsync, line_start, frame_start;
    cfg_t        drv = DEF;

    int checks = 0;
    int failures = 0;

    cfg_t m_act, m_sh;
    int   m_n = 0;
    bit   m_pend = 0, m_app = 0, m_err = 0;

    always #5 clk = ~clk;

    h14tx_timings_generator #(
        .BitWidth(12), .BitHeight(11),
        .HActive(20), .HSyncStart(24), .HSyncEnd(27), .HTotal(30),
        .VActive(10), .VSyncStart(12), .VSyncEnd(14), .VTotal(16),
        .HSyncPol(1'b1), .VSyncPol(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_active(drv.ha[11:0]), .cfg_h_sync_start(drv.hss[11:0]),
        .cfg_h_sync_end(drv.hse[11:0]), .cfg_h_total(drv.ht[11:0]),
        .cfg_v_active(drv.va[10:0]), .cfg_v_sync_start(drv.vss[10:0]),
        .cfg_v_sync_end(drv.vse[10:0]), .cfg_v_total(drv.vt[10:0]),
        .cfg_hsync_pol(drv.hp), .cfg_vsync_pol(drv.vp),
        .cfg_applied(cfg_applied), .cfg_error(cfg_error),
        .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start)
    );

    function automatic bit cfg_ok(input cfg_t c);
        return c.ha >= 1 && c.ha <= c.hss && c.hss < c.hse && c.hse <= c.ht && c.ht >= 2
            && c.va >= 1 && c.va <= c.vss && c.vss < c.vse && c.vse <= c.vt && c.vt >= 1;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.ht  = int'($urandom_range(12, 2));
        c.ha  = int'($urandom_range(c.ht - 1, 1));
        c.hss = int'($urandom_range(c.ht - 1, c.ha));
        c.hse = int'($urandom_range(c.ht, c.hss + 1));
        c.vt  = int'($urandom_range(8, 2));
        c.va  = int'($urandom_range(c.vt - 1, 1));
        c.vss = int'($urandom_range(c.vt - 1, c.va));
        c.vse = int'($urandom_range(c.vt, c.vss + 1));
        c.hp  = 1'($urandom_range(1, 0));
        c.vp  = 1'($urandom_range(1, 0));
        if ($urandom_range(3, 0) == 0) begin
            case ($urandom_range(7, 0))
                0: c.ha  = int'($urandom_range(15, 0));
                1: c.hss = int'($urandom_range(15, 0));
                2: c.hse = int'($urandom_range(15, 0));
                3: c.ht  = int'($urandom_range(15, 0));
                4: c.va  = int'($urandom_range(15, 0));
                5: c.vss = int'($urandom_range(15, 0));
                6: c.vse = int'($urandom_range(15, 0));
                default: c.vt = int'($urandom_range(15, 0));
            endcase
        end
        return c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, m_n);
        end
    endtask

    task automatic step(input bit e, input bit v, input bit rb);
        bit   pend_before;
        int   ex, ey;
        en = e; cfg_valid = v; rst_n = rb;
        @(posedge clk);
        if (!rb) begin
            m_act = DEF; m_sh = DEF; m_n = 0; m_pend = 0; m_app = 0; m_err = 0;
        end else begin
            pend_before = m_pend;
            m_app = 0; m_err = 0;
            if (e) begin
                m_n++;
                if (m_n == m_act.ht * m_act.vt) begin
                    m_n = 0;
                    if (pend_before) begin
                        m_act = m_sh; m_pend = 0; m_app = 1;
                    end
                end
            end
            if (v && !pend_before) begin
                if (cfg_ok(drv)) begin m_sh = drv; m_pend = 1; end
                else m_err = 1;
            end
        end
        #1;
        ex = m_n % m_act.ht;
        ey = m_n / m_act.ht;
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("de", int'(de), int'(ex < m_act.ha && ey < m_act.va));
        chk("hsync", int'(hsync), int'((ex >= m_act.hss && ex < m_act.hse) == m_act.hp));
        chk("vsync", int'(vsync), int'((ey >= m_act.vss && ey < m_act.vse) == m_act.vp));
        chk("line_start", int'(line_start), int'(ex == 0));
        chk("frame_start", int'(frame_start), int'(m_n == 0));
        chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
        chk("cfg_applied", int'(cfg_applied), int'(m_app));
        chk("cfg_error", int'(cfg_error), int'(m_err));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && m_pend; i++) step(1, 0, 1);
        chk("idle_timeout", int'(cfg_ready), 1);
    endtask

    initial begin
        m_act = DEF; m_sh = DEF;
        step(1, 0, 0);
        step(1, 0, 0);
        // Two full default frames.
        for (int i = 0; i < 2 * 480 + 5; i++) step(1, 0, 1);

        // Mid-frame offer of a tiny 8x5 raster with inverted polarities.
        drv = '{ha: 4, hss: 5, hse: 6, ht: 8, va: 2, vss: 3, vse: 4, vt: 5, hp: 1'b0, vp: 1'b0};
        step(1, 1, 1);
        for (int i = 0; i < 600 && m_pend; i++) step(1, 0, 1);
        chk("applied_timeout", int'(m_pend), 0);
        for (int i = 0; i < 3 * 40; i++) step(1, 0, 1);

        // Invalid offer: sync start before end of active.
        drv = '{ha: 4, hss: 3, hse: 6, ht: 8, va: 2, vss: 3, vse: 4, vt: 5, hp: 1'b0, vp: 1'b0};
        step(1, 1, 1);
        step(1, 0, 1);
        for (int i = 0; i < 45; i++) step(1, 0, 1);

        // Offer landing exactly on the frame-wrap cycle.
        for (int i = 0; i < 100 && m_n != m_act.ht * m_act.vt - 1; i++) step(1, 0, 1);
        drv = '{ha: 5, hss: 6, hse: 8, ht: 9, va: 3, vss: 3, vse: 4, vt: 4, hp: 1'b1, vp: 1'b0};
        step(1, 1, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 1);
        wait_idle();

        // Hold en low for 7 cycles mid-line.
        for (int i = 0; i < 100 && (m_n % m_act.ht) != 3; i++) step(1, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 1);
        for (int i = 0; i < 80; i++) step(1, 0, 1);

        // Randomized traffic: gated enable, random offers (some invalid).
        for (int i = 0; i < 4000; i++) begin
            drv = rand_cfg();
            step(1'($urandom_range(9, 0) != 0), 1'($urandom_range(7, 0) == 0), 1);
        end

        // Reset while a set is pending; it must be dropped.
        wait_idle();
        drv = '{ha: 3, hss: 3, hse: 4, ht: 5, va: 2, vss: 2, vse: 3, vt: 3, hp: 1'b1, vp: 1'b1};
        step(1, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 1);
        chk("pending_before_reset", int'(cfg_ready), 0);
        step(1, 0, 0);
        for (int i = 0; i < 2 * 480 + 10; i++) step(1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
